keypad_emulator: RTL and testbench

Synthesizable 4x4 matrix-keypad model: the key side of the row/column scan interface. It watches the row lines driven by a keypad scanner and returns column lines as if a selected key were physically pressed. Optional contact bounce is modelled on press and release. It supports FPGA loopback tests of the scanner without a physical keypad, with keypresses injected through a valid/ready command port.

---
 rtl/keypad_emulator.sv | 143 ++++++++++++++
 tb/tb_keypad_emulator.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_emulator.sv
// Key side of a 4x4 row/column keypad scan: returns column lines for one injected
// keypress, with optional contact bounce on press and release.
module keypad_emulator #(
    parameter int BOUNCE_CYCLES = 8
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic [3:0]  keypad_rows,
    output logic [3:0]  keypad_cols,
    input  logic [3:0]  key_code,
    input  logic [15:0] hold_cycles,
    input  logic        bounce_en,
    input  logic        press_valid,
    output logic        press_ready,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_BOUNCE,
        HOLD,
        RELEASE_BOUNCE
    } state_t;

    localparam logic [15:0] BOUNCE_LOAD = 16'(BOUNCE_CYCLES);

    state_t      state_reg;
    logic [15:0] count_reg;
    logic [1:0]  row_reg;
    logic [1:0]  col_reg;
    logic [15:0] hold_reg;
    logic        bounce_reg;
    logic [3:0]  cols_reg;
    logic        ready_reg;
    logic        busy_reg;
    logic        done_reg;

    logic        accept;
    logic        phase_odd;
    logic        contact;
    logic [15:0] hold_eff;

    assign accept    = press_valid && ready_reg;
    assign hold_eff  = (hold_cycles == 16'd0) ? 16'd1 : hold_cycles;
    // Phase index n = BOUNCE_CYCLES - count, so its parity needs no subtractor.
    assign phase_odd = BOUNCE_LOAD[0] ^ count_reg[0];

    always_comb begin
        contact = 1'b0;
        case (state_reg)
            PRESS_BOUNCE:   contact = phase_odd;
            HOLD:           contact = 1'b1;
            RELEASE_BOUNCE: contact = ~phase_odd;
            default:        contact = 1'b0;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_reg  <= IDLE;
            count_reg  <= 16'd0;
            row_reg    <= 2'd0;
            col_reg    <= 2'd0;
            hold_reg   <= 16'd0;
            bounce_reg <= 1'b0;
            cols_reg   <= 4'b0000;
            ready_reg  <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            cols_reg <= (contact && keypad_rows[row_reg]) ? 4'(4'b0001 << col_reg) : 4'b0000;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        row_reg    <= key_code[3:2];
                        col_reg    <= key_code[1:0];
                        hold_reg   <= hold_eff;
                        bounce_reg <= bounce_en;
                        ready_reg  <= 1'b0;
                        busy_reg   <= 1'b1;
                        if (bounce_en) begin
                            state_reg <= PRESS_BOUNCE;
                            count_reg <= BOUNCE_LOAD;
                        end else begin
                            state_reg <= HOLD;
                            count_reg <= hold_eff;
                        end
                    end else begin
                        ready_reg <= 1'b1;
                        busy_reg  <= 1'b0;
                    end
                end
                PRESS_BOUNCE: begin
                    if (count_reg == 16'd1) begin
                        state_reg <= HOLD;
                        count_reg <= hold_reg;
                    end else begin
                        count_reg <= count_reg - 16'd1;
                    end
                end
                HOLD: begin
                    if (count_reg == 16'd1) begin
                        if (bounce_reg) begin
                            state_reg <= RELEASE_BOUNCE;
                            count_reg <= BOUNCE_LOAD;
                        end else begin
                            state_reg <= IDLE;
                            count_reg <= 16'd0;
                            ready_reg <= 1'b1;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end
                    end else begin
                        count_reg <= count_reg - 16'd1;
                    end
                end
                RELEASE_BOUNCE: begin
                    if (count_reg == 16'd1) begin
                        state_reg <= IDLE;
                        count_reg <= 16'd0;
                        ready_reg <= 1'b1;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end else begin
                        count_reg <= count_reg - 16'd1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    count_reg <= 16'd0;
                end
            endcase
        end
    end

    assign keypad_cols = cols_reg;
    assign press_ready = ready_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed bench for keypad_emulator: clean, mismatch, bounce, scanner rotation,
// handshake and mid-hold reset scenarios.
module tb_keypad_emulator;

    localparam int B = 8;

    logic        clk_in = 1'b0;
    logic        rst;
    logic [3:0]  keypad_rows;
    logic [3:0]  keypad_cols;
    logic [3:0]  key_code;
    logic [15:0] hold_cycles;
    logic        bounce_en;
    logic        press_valid;
    logic        press_ready;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    keypad_emulator #(.BOUNCE_CYCLES(B)) dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .keypad_rows (keypad_rows),
        .keypad_cols (keypad_cols),
        .key_code    (key_code),
        .hold_cycles (hold_cycles),
        .bounce_en   (bounce_en),
        .press_valid (press_valid),
        .press_ready (press_ready),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk_in = ~clk_in;

    // Contact closed during state cycle k (k = 0 is the cycle after accept).
    function automatic bit closed(int k, int b, int h, bit bnc);
        if (k < 0) return 1'b0;
        if (!bnc) return k < h;
        if (k < b) return (k % 2) == 1;
        if (k < b + h) return 1'b1;
        if (k < 2 * b + h) return ((k - b - h) % 2) == 0;
        return 1'b0;
    endfunction

    // Presents a command before an edge and drops press_valid after it; returns at sample 0.
    task automatic issue(input logic [3:0] key, input logic [15:0] hold, input logic bnc);
        @(negedge clk_in);
        key_code    = key;
        hold_cycles = hold;
        bounce_en   = bnc;
        press_valid = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        press_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        keypad_rows = 4'b0000; key_code = 4'd0; hold_cycles = 16'd0;
        bounce_en = 1'b0; press_valid = 1'b0;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        checks += 4;
        if (press_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got %b expected 0", press_ready); end
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b expected 0", busy); end
        if (keypad_cols !== 4'b0000) begin failures++; $display("FAIL reset_cols got %b expected 0000", keypad_cols); end
        if (done !== 1'b0) begin failures++; $display("FAIL reset_done got %b expected 0", done); end
        rst = 1'b0;
        @(negedge clk_in);
        checks += 2;
        if (press_ready !== 1'b1) begin failures++; $display("FAIL post_reset_ready got %b expected 1", press_ready); end
        if (busy !== 1'b0) begin failures++; $display("FAIL post_reset_busy got %b expected 0", busy); end
        $display("test_reset done");
    endtask

    task automatic test_clean;
        logic [3:0] exp_cols;
        keypad_rows = 4'b0010;
        issue(4'b0110, 16'd5, 1'b0);
        for (int i = 0; i < 8; i++) begin
            exp_cols = closed(i - 1, B, 5, 1'b0) ? 4'b0100 : 4'b0000;
            checks += 3;
            if (keypad_cols !== exp_cols) begin failures++; $display("FAIL clean_cols[%0d] got %b expected %b", i, keypad_cols, exp_cols); end
            if (busy !== (i < 5)) begin failures++; $display("FAIL clean_busy[%0d] got %b expected %b", i, busy, (i < 5)); end
            if (done !== (i == 5)) begin failures++; $display("FAIL clean_done[%0d] got %b expected %b", i, done, (i == 5)); end
            @(negedge clk_in);
        end
        $display("test_clean done");
    endtask

    task automatic test_mismatch;
        keypad_rows = 4'b0001;
        issue(4'b0110, 16'd5, 1'b0);
        for (int i = 0; i < 8; i++) begin
            checks += 3;
            if (keypad_cols !== 4'b0000) begin failures++; $display("FAIL mismatch_cols[%0d] got %b expected 0000", i, keypad_cols); end
            if (busy !== (i < 5)) begin failures++; $display("FAIL mismatch_busy[%0d] got %b expected %b", i, busy, (i < 5)); end
            if (done !== (i == 5)) begin failures++; $display("FAIL mismatch_done[%0d] got %b expected %b", i, done, (i == 5)); end
            @(negedge clk_in);
        end
        $display("test_mismatch done");
    endtask

    task automatic test_bounce;
        logic [3:0] exp_cols;
        keypad_rows = 4'b1000;
        issue(4'b1111, 16'd4, 1'b1);
        for (int i = 0; i < 24; i++) begin
            exp_cols = closed(i - 1, B, 4, 1'b1) ? 4'b1000 : 4'b0000;
            checks += 3;
            if (keypad_cols !== exp_cols) begin failures++; $display("FAIL bounce_cols[%0d] got %b expected %b", i, keypad_cols, exp_cols); end
            if (busy !== (i < 20)) begin failures++; $display("FAIL bounce_busy[%0d] got %b expected %b", i, busy, (i < 20)); end
            if (done !== (i == 20)) begin failures++; $display("FAIL bounce_done[%0d] got %b expected %b", i, done, (i == 20)); end
            @(negedge clk_in);
        end
        $display("test_bounce done");
    endtask

    task automatic test_rotation;
        logic [3:0] exp_cols;
        logic [3:0] applied;
        keypad_rows = 4'b0001;
        issue(4'b0101, 16'd16, 1'b0);
        applied = keypad_rows;
        for (int i = 0; i < 20; i++) begin
            exp_cols = (closed(i - 1, B, 16, 1'b0) && applied[1]) ? 4'b0010 : 4'b0000;
            checks += 2;
            if (keypad_cols !== exp_cols) begin failures++; $display("FAIL rotation_cols[%0d] got %b expected %b", i, keypad_cols, exp_cols); end
            if (done !== (i == 16)) begin failures++; $display("FAIL rotation_done[%0d] got %b expected %b", i, done, (i == 16)); end
            keypad_rows = {keypad_rows[2:0], keypad_rows[3]};
            applied = keypad_rows;
            @(negedge clk_in);
        end
        $display("test_rotation done");
    endtask

    task automatic test_back_to_back;
        logic [3:0] exp_cols [0:6];
        logic       exp_busy [0:6];
        logic       exp_done [0:6];
        logic       exp_rdy  [0:6];
        exp_cols = '{4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b1000, 4'b0000};
        exp_busy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        exp_done = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        exp_rdy  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        keypad_rows = 4'b0011;
        @(negedge clk_in);
        key_code = 4'b0110; hold_cycles = 16'd3; bounce_en = 1'b0; press_valid = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        // Second command waits on the bus with press_valid still high.
        key_code = 4'b0011; hold_cycles = 16'd0;
        for (int i = 0; i < 7; i++) begin
            checks += 4;
            if (keypad_cols !== exp_cols[i]) begin failures++; $display("FAIL b2b_cols[%0d] got %b expected %b", i, keypad_cols, exp_cols[i]); end
            if (busy !== exp_busy[i]) begin failures++; $display("FAIL b2b_busy[%0d] got %b expected %b", i, busy, exp_busy[i]); end
            if (done !== exp_done[i]) begin failures++; $display("FAIL b2b_done[%0d] got %b expected %b", i, done, exp_done[i]); end
            if (press_ready !== exp_rdy[i]) begin failures++; $display("FAIL b2b_ready[%0d] got %b expected %b", i, press_ready, exp_rdy[i]); end
            if (i == 4) press_valid = 1'b0;
            @(negedge clk_in);
        end
        press_valid = 1'b0;
        $display("test_back_to_back done");
    endtask

    task automatic test_reset_mid_hold;
        keypad_rows = 4'b0010;
        issue(4'b0110, 16'd10, 1'b0);
        repeat (3) @(negedge clk_in);
        rst = 1'b1;
        @(negedge clk_in);
        checks += 3;
        if (keypad_cols !== 4'b0000) begin failures++; $display("FAIL midrst_cols got %b expected 0000", keypad_cols); end
        if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got %b expected 0", busy); end
        if (press_ready !== 1'b0) begin failures++; $display("FAIL midrst_ready got %b expected 0", press_ready); end
        rst = 1'b0;
        @(negedge clk_in);
        checks += 2;
        if (press_ready !== 1'b1) begin failures++; $display("FAIL midrst_ready_after got %b expected 1", press_ready); end
        if (keypad_cols !== 4'b0000) begin failures++; $display("FAIL midrst_cols_after got %b expected 0000", keypad_cols); end
        for (int i = 0; i < 12; i++) begin
            checks += 2;
            if (done !== 1'b0) begin failures++; $display("FAIL midrst_no_done[%0d] got %b expected 0", i, done); end
            if (keypad_cols !== 4'b0000) begin failures++; $display("FAIL midrst_idle_cols[%0d] got %b expected 0000", i, keypad_cols); end
            @(negedge clk_in);
        end
        issue(4'b0110, 16'd2, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checks += 3;
            if (busy !== (i < 2)) begin failures++; $display("FAIL midrst_new_busy[%0d] got %b expected %b", i, busy, (i < 2)); end
            if (done !== (i == 2)) begin failures++; $display("FAIL midrst_new_done[%0d] got %b expected %b", i, done, (i == 2)); end
            if (keypad_cols !== ((i == 1 || i == 2) ? 4'b0100 : 4'b0000)) begin
                failures++; $display("FAIL midrst_new_cols[%0d] got %b", i, keypad_cols);
            end
            @(negedge clk_in);
        end
        $display("test_reset_mid_hold done");
    endtask

    initial begin
        test_reset();
        test_clean();
        test_mismatch();
        test_bounce();
        test_rotation();
        test_back_to_back();
        test_reset_mid_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
